// File: rtl/bsg_sync_gray_ptr_reader.sv
// Read-side pointer logic of an async FIFO: synchronizes the foreign Gray write
// pointer, tracks the local read pointer and launches a registered Gray read pointer.
module bsg_sync_gray_ptr_reader #(
    parameter int lg_size_p = 3
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [lg_size_p:0]   wptr_gray_async_i,
    input  logic                 yumi_i,
    output logic                 valid_o,
    output logic [lg_size_p-1:0] rptr_bin_o,
    output logic [lg_size_p:0]   rptr_gray_o,
    output logic [lg_size_p:0]   count_o,
    output logic                 overflow_o
);
    localparam int ptr_w = lg_size_p + 1;
    localparam logic [ptr_w-1:0] depth = ptr_w'(1 << lg_size_p);

    logic [ptr_w-1:0] sync1, sync2, wbin, rbin, rbin_next, rgray, count;
    logic             ovf;

    // Pure flop-to-flop chain so the first stage may resolve metastability.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= wptr_gray_async_i;
            sync2 <= sync1;
        end
    end

    // Each binary bit is the parity of the Gray bits at and above it.
    for (genvar i = 0; i < ptr_w; i++) begin : g_g2b
        assign wbin[i] = ^sync2[ptr_w-1:i];
    end

    assign count     = wbin - rbin;
    assign valid_o   = |count;
    assign rbin_next = rbin + ptr_w'(yumi_i & valid_o);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rbin  <= '0;
            rgray <= '0;
            ovf   <= 1'b0;
        end else begin
            rbin  <= rbin_next;
            rgray <= rbin_next ^ (rbin_next >> 1);
            if (count > depth)
                ovf <= 1'b1;
        end
    end

    assign rptr_bin_o  = rbin[lg_size_p-1:0];
    assign rptr_gray_o = rgray;
    assign count_o     = count;
    assign overflow_o  = ovf;
endmodule

// File: tb/tb_bsg_sync_gray_ptr_reader.sv
// Scoreboard bench: driver pushes model predictions per edge, monitor compares on negedge.
module tb_bsg_sync_gray_ptr_reader;
    localparam int LG = 3;
    localparam int PW = LG + 1;
    localparam int MOD = 1 << PW;
    localparam int DEPTH = 1 << LG;

    logic          clk;
    logic          reset;
    logic [PW-1:0] wptr_gray;
    logic          yumi;
    logic          valid;
    logic [LG-1:0] rptr_bin;
    logic [PW-1:0] rptr_gray;
    logic [PW-1:0] count;
    logic          overflow;

    bsg_sync_gray_ptr_reader #(.lg_size_p(LG)) dut (
        .clk_i(clk),
        .reset_i(reset),
        .wptr_gray_async_i(wptr_gray),
        .yumi_i(yumi),
        .valid_o(valid),
        .rptr_bin_o(rptr_bin),
        .rptr_gray_o(rptr_gray),
        .count_o(count),
        .overflow_o(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit vld;
        int rb;
        int rg;
        int cnt;
        bit ovf;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: history of write pointers seen at each edge, plus read count.
    int hist[$];
    int m_rbin;
    bit m_ovf;

    function automatic int to_gray(input int b);
        return (b ^ (b >> 1)) % MOD;
    endfunction

    function automatic int from_gray(input int g);
        for (int b = 0; b < MOD; b++)
            if (to_gray(b) == g) return b;
        return 0;
    endfunction

    function automatic int m_wbin();
        if (hist.size() < 2) return 0;
        return from_gray(hist[hist.size()-2]);
    endfunction

    function automatic int m_count();
        return (m_wbin() - m_rbin + MOD) % MOD;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Apply one cycle: writer at binary position wb, consumer asserting y.
    task automatic cyc(input int wb, input bit y);
        int   g;
        exp_t e;
        g = to_gray(wb % MOD);
        wptr_gray = PW'(g);
        yumi = y;
        @(posedge clk);
        #1;
        if (m_count() > DEPTH) m_ovf = 1'b1;
        if (y && m_count() != 0) m_rbin = (m_rbin + 1) % MOD;
        hist.push_back(g);
        if (hist.size() > 4) void'(hist.pop_front());
        e.cnt = m_count();
        e.vld = (e.cnt != 0);
        e.rb  = m_rbin % DEPTH;
        e.rg  = to_gray(m_rbin);
        e.ovf = m_ovf;
        q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("rst_valid", int'(valid), 0);
        chk("rst_rptr_bin", int'(rptr_bin), 0);
        chk("rst_rptr_gray", int'(rptr_gray), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_overflow", int'(overflow), 0);
        hist.delete();
        m_rbin = 0;
        m_ovf = 1'b0;
        wptr_gray = '0;
        yumi = 1'b0;
        #1;
        reset = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("valid", int'(valid), int'(e.vld));
                chk("rptr_bin", int'(rptr_bin), e.rb);
                chk("rptr_gray", int'(rptr_gray), e.rg);
                chk("count", int'(count), e.cnt);
                chk("overflow", int'(overflow), int'(e.ovf));
            end
        end
    end

    initial begin : driver
        int wp;
        m_rbin = 0;
        m_ovf = 1'b0;
        wptr_gray = '0;
        yumi = 1'b0;
        reset = 1'b1;
        #1;
        chk("init_valid", int'(valid), 0);
        chk("init_count", int'(count), 0);
        chk("init_rptr_gray", int'(rptr_gray), 0);
        #2;
        reset = 1'b0;

        // Single entry arrives after two edges, then is consumed.
        cyc(0, 0); cyc(0, 0);
        cyc(1, 0); cyc(1, 0); cyc(1, 0);
        cyc(1, 1); cyc(1, 0);

        // Full FIFO, drain, then writer wraps with reader keeping up.
        do_reset();
        for (int i = 0; i < 3; i++) cyc(8, 0);
        for (int i = 0; i < 8; i++) cyc(8, 1);
        for (int i = 1; i <= 8; i++) cyc(8 + i, 1);
        for (int i = 0; i < 4; i++) cyc(0, 1);
        // yumi while empty must not move the pointer.
        for (int i = 0; i < 4; i++) cyc(0, 1);

        // Sync update and yumi landing on the same edge.
        do_reset();
        for (int i = 0; i < 3; i++) cyc(2, 0);
        cyc(2, 1);
        cyc(3, 0);
        cyc(3, 1);
        cyc(3, 0);

        // Mid-operation reset with rptr=5, count=3.
        do_reset();
        for (int i = 0; i < 3; i++) cyc(8, 0);
        for (int i = 0; i < 5; i++) cyc(8, 1);
        cyc(8, 0);
        do_reset();
        for (int i = 0; i < 3; i++) cyc(0, 0);

        // Writer overruns by one: sticky overflow survives draining.
        do_reset();
        for (int i = 0; i < 4; i++) cyc(9, 0);
        for (int i = 0; i < 12; i++) cyc(9, 1);
        do_reset();
        cyc(0, 0);

        // Random traffic within the legal occupancy envelope.
        do_reset();
        wp = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 1) == 1 && ((wp - m_rbin + MOD) % MOD) < DEPTH)
                wp = (wp + 1) % MOD;
            cyc(wp, 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 12; i++) cyc(wp, 1);

        @(negedge clk);
        #1;
        chk("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
